// File: rtl/nios_pll_reset_sequencer.sv
// PLL and system reset sequencer for the Nios platform.
// Runs on the free-running PLL reference clock. It pulses the PLL reset, waits for lock with a
// bounded timeout and retry budget, and qualifies lock stability before it releases the
// PLL-clocked domains. A lock loss in RUN re-sequences from PLL reset.
module nios_pll_reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned SYS_RST_HOLD        = 8,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       clear_fault,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam logic [31:0] PllRstLast  = 32'(PLL_RST_CYCLES - 1);
    localparam logic [31:0] TimeoutLast = 32'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [31:0] StableLast  = 32'(LOCK_STABLE_CYCLES - 1);
    localparam logic [31:0] HoldLast    = 32'(SYS_RST_HOLD - 1);
    localparam logic [3:0]  MaxRetries  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StPllReset,
        StWaitLock,
        StStabilize,
        StRelease,
        StRun,
        StFault
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  loss_q, loss_d;
    logic        sync1_q, locked_s_q;
    logic        pll_rst_q, sys_reset_q, ready_q, fault_q;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    // Next-state, shared counter and event counter logic.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        unique case (state_q)
            StPllReset: begin
                if (cnt_q == PllRstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                // Lock takes priority over a timeout on the same cycle.
                if (locked_s_q) begin
                    state_d = StStabilize;
                end else if (cnt_q == TimeoutLast) begin
                    retry_d = retry_q + 4'd1;
                    state_d = (retry_d == MaxRetries) ? StFault : StPllReset;
                end
            end
            StStabilize: begin
                if (!locked_s_q)               state_d = StWaitLock;
                else if (cnt_q == StableLast)  state_d = StRelease;
            end
            StRelease: begin
                if (!locked_s_q) begin
                    state_d = StPllReset;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRun;
                    retry_d = 4'd0;
                end
            end
            StRun: begin
                if (!locked_s_q) begin
                    state_d = StPllReset;
                    loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end
            end
            StFault: begin
                if (clear_fault) begin
                    state_d = StPllReset;
                    retry_d = 4'd0;
                end
            end
            default: state_d = StPllReset;
        endcase

        // Counter restarts on any transition; it idles in states that do not time anything.
        if (state_d != state_q)                         cnt_d = 32'd0;
        else if (state_q == StRun || state_q == StFault) cnt_d = cnt_q;
        else                                             cnt_d = cnt_q + 32'd1;
    end

    // State, counters and outputs; outputs are decoded from the next state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= StPllReset;
            cnt_q       <= 32'd0;
            retry_q     <= 4'd0;
            loss_q      <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == StPllReset) || (state_d == StFault);
            sys_reset_q <= (state_d != StRun);
            ready_q     <= (state_d == StRun);
            fault_q     <= (state_d == StFault);
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_reset       = sys_reset_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_nios_pll_reset_sequencer.sv
// Directed bench for nios_pll_reset_sequencer with small timing parameters.
module tb_nios_pll_reset_sequencer;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       clear_fault;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    int ntests = 0;
    int nfail  = 0;

    nios_pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .PLL_RST_CYCLES     (4),
        .SYS_RST_HOLD       (4),
        .MAX_RETRIES        (2)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .clear_fault    (clear_fault),
        .pll_rst        (pll_rst),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .fault          (fault),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_pll_rst"}, {31'd0, pll_rst}, 32'd1);
        chk({tag, "_sys_reset"}, {31'd0, sys_reset}, 32'd1);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_retry"}, {28'd0, retry_count}, 32'd0);
        chk({tag, "_loss"}, {24'd0, lock_loss_count}, 32'd0);
    endtask

    // One run-time lock loss followed by a clean relock back into RUN.
    task automatic lose_and_relock();
        pll_locked = 1'b0;
        repeat (7) tick();
        pll_locked = 1'b1;
        repeat (15) tick();
    endtask

    initial begin
        rst         = 1'b1;
        pll_locked  = 1'b0;
        clear_fault = 1'b0;
        repeat (3) tick();
        chk_idle_reset("reset");

        // Clean start: pll_rst holds 4 edges, lock arrives 10 cycles after it falls.
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("start_pll_rst", {31'd0, pll_rst}, (k < 4) ? 32'd1 : 32'd0);
        end
        repeat (10) tick();
        pll_locked = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("clean_sys_reset", {31'd0, sys_reset}, (k < 15) ? 32'd1 : 32'd0);
        end
        chk("clean_ready", {31'd0, ready}, 32'd1);
        chk("clean_retry", {28'd0, retry_count}, 32'd0);

        // Run-time loss: sys_reset rises 3 edges later, then a 4-cycle pll_rst pulse.
        pll_locked = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("loss_sys_reset", {31'd0, sys_reset}, (k < 3) ? 32'd0 : 32'd1);
            chk("loss_pll_rst", {31'd0, pll_rst}, (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
        end
        chk("loss_ready", {31'd0, ready}, 32'd0);
        chk("loss_count1", {24'd0, lock_loss_count}, 32'd1);

        // Lock bounce: lock rises, then drops for 3 cycles during STABILIZE.
        pll_locked = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (k == 5) pll_locked = 1'b0;
            if (k == 8) pll_locked = 1'b1;
            chk("bounce_sys_reset", {31'd0, sys_reset}, (k < 23) ? 32'd1 : 32'd0);
            chk("bounce_pll_rst", {31'd0, pll_rst}, 32'd0);
        end
        chk("bounce_ready", {31'd0, ready}, 32'd1);

        // Mid-sequence reset: re-enter RELEASE, then assert rst there.
        pll_locked = 1'b0;
        repeat (7) tick();
        pll_locked = 1'b1;
        repeat (12) tick();
        chk("release_loss", {24'd0, lock_loss_count}, 32'd2);
        chk("release_sys_reset", {31'd0, sys_reset}, 32'd1);
        chk("release_pll_rst", {31'd0, pll_rst}, 32'd0);
        rst = 1'b1;
        #1;
        chk_idle_reset("midrst");
        tick();
        rst = 1'b0;
        // Lock held through reset: restart takes 4 + 1 + 8 + 4 edges.
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk("restart_pll_rst", {31'd0, pll_rst}, (k < 4) ? 32'd1 : 32'd0);
            chk("restart_sys_reset", {31'd0, sys_reset}, (k < 17) ? 32'd1 : 32'd0);
        end
        chk("restart_ready", {31'd0, ready}, 32'd1);

        // Timeouts to fault with lock held low.
        pll_locked = 1'b0;
        for (int k = 1; k <= 75; k++) begin
            tick();
            if (k == 38) chk("to1_before", {31'd0, pll_rst}, 32'd0);
            if (k == 39) begin
                chk("to1_pll_rst", {31'd0, pll_rst}, 32'd1);
                chk("to1_retry", {28'd0, retry_count}, 32'd1);
            end
            if (k == 42) chk("to1_pulse_end", {31'd0, pll_rst}, 32'd1);
            if (k == 43) chk("to1_pulse_off", {31'd0, pll_rst}, 32'd0);
            if (k == 74) chk("to2_before", {31'd0, fault}, 32'd0);
        end
        chk("fault_flag", {31'd0, fault}, 32'd1);
        chk("fault_retry", {28'd0, retry_count}, 32'd2);
        chk("fault_pll_rst", {31'd0, pll_rst}, 32'd1);
        chk("fault_sys_reset", {31'd0, sys_reset}, 32'd1);
        repeat (5) tick();
        chk("fault_holds", {31'd0, fault}, 32'd1);

        // Fault recovery; lock arrives on the timeout cycle, so lock must win.
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("clear_fault_flag", {31'd0, fault}, 32'd0);
        chk("clear_retry", {28'd0, retry_count}, 32'd0);
        chk("clear_pll_rst", {31'd0, pll_rst}, 32'd1);
        for (int k = 2; k <= 49; k++) begin
            tick();
            if (k == 34) pll_locked = 1'b1;
            if (k == 37) begin
                chk("race_pll_rst", {31'd0, pll_rst}, 32'd0);
                chk("race_retry", {28'd0, retry_count}, 32'd0);
            end
            if (k == 48) chk("recover_before", {31'd0, ready}, 32'd0);
        end
        chk("recover_ready", {31'd0, ready}, 32'd1);
        chk("recover_fault", {31'd0, fault}, 32'd0);
        chk("recover_retry", {28'd0, retry_count}, 32'd0);

        // Saturation of the lock-loss counter (count is 1 here after the reset).
        lose_and_relock();
        chk("sat_loss2", {24'd0, lock_loss_count}, 32'd2);
        for (int i = 0; i < 252; i++) lose_and_relock();
        chk("sat_loss254", {24'd0, lock_loss_count}, 32'd254);
        lose_and_relock();
        chk("sat_loss255", {24'd0, lock_loss_count}, 32'd255);
        lose_and_relock();
        chk("sat_loss_hold", {24'd0, lock_loss_count}, 32'd255);
        chk("sat_ready", {31'd0, ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
